// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants for the UART host-side register sequencer:
//               register indices, FSM state encoding and reset defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Register indices presented on the four-way select decoder
    localparam logic [1:0] ADDR_BAUD  = 2'd0;
    localparam logic [1:0] ADDR_MODTX = 2'd1;
    localparam logic [1:0] ADDR_TXFF  = 2'd2;
    localparam logic [1:0] ADDR_TX    = 2'd3;

    // Default baud divisor reset value
    localparam logic [7:0] BAUD_RST_DFLT = 8'd27;

    // Host sequencer state encoding
    localparam int         c_state_w    = 3;
    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_setup   = 3'd1;
    localparam logic [2:0] c_st_wait    = 3'd2;
    localparam logic [2:0] c_st_strobe  = 3'd3;
    localparam logic [2:0] c_st_ack     = 3'd4;
    localparam logic [2:0] c_st_release = 3'd5;

    // A write must stall while its target cannot accept data
    function automatic logic write_stalls(input logic       wr,
                                          input logic [1:0] addr,
                                          input logic       txff_full,
                                          input logic       tx_busy);
        return wr && (((addr == ADDR_TXFF) && txff_full) ||
                      ((addr == ADDR_TX)   && tx_busy));
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_host_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_host_ctrl_if
// Description : Single-beat host request/acknowledge bus for the UART
//               register sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_host_ctrl_if #(
    parameter int DW = 8
) ();

    logic          req;
    logic          wr;
    logic [1:0]    addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic          err;
    logic [DW-1:0] rdata;

    // Host side: issues requests, receives completions
    modport master (
        output req, wr, addr, wdata,
        input  ack, err, rdata
    );

    // Sequencer side: accepts requests, returns completions
    modport slave (
        input  req, wr, addr, wdata,
        output ack, err, rdata
    );

endinterface
`default_nettype wire

// File: rtl/uart_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_wait_timer
// Description : Loadable stall counter with synchronous clear, count enable
//               and a terminal-count flag raised at WAIT_MAX-1.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_wait_timer #(
    parameter int WAIT_MAX = 16,
    parameter int CW       = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          i_clr,
    input  wire logic          i_ld,
    input  wire logic [CW-1:0] i_ld_val,
    input  wire logic          i_en,
    output logic               o_tc
);

    localparam logic [CW-1:0] c_tc_val = CW'(WAIT_MAX - 1);

    logic [CW-1:0] r_cnt;

    // Counter: clear beats load, load beats increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_ld) begin
            r_cnt <= i_ld_val;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == c_tc_val);

endmodule
`default_nettype wire

// File: rtl/uart_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_host_ctrl
// Description : Host-side register access sequencer for the UART. Drives the
//               register-select decoder and write strobe, keeps shadow copies
//               of the baud divisor and mode registers, stalls writes to a
//               busy TX path and completes stuck stalls with an error.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_host_ctrl
    import uart_pkg::*;
#(
    parameter int            DW       = 8,
    parameter logic [DW-1:0] BAUD_RST = DW'(BAUD_RST_DFLT),
    parameter logic [DW-1:0] MODE_RST = '0,
    parameter int            WAIT_MAX = 16
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    uart_host_ctrl_if.slave     host,
    output logic                dec_ena,
    output logic [1:0]          dec_sel,
    output logic                reg_we,
    output logic [DW-1:0]       reg_wdata,
    output logic [DW-1:0]       baud_div,
    output logic [DW-1:0]       mode_cfg,
    input  wire logic           txff_full,
    input  wire logic           tx_busy
);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_next;

    logic          r_wr;
    logic [1:0]    r_addr;
    logic [DW-1:0] r_wdata;

    logic          r_dec_ena;
    logic [1:0]    r_dec_sel;
    logic          r_reg_we;
    logic [DW-1:0] r_reg_wdata;
    logic          r_ack;
    logic          r_err;
    logic [DW-1:0] r_rdata;
    logic [DW-1:0] r_baud_div;
    logic [DW-1:0] r_mode_cfg;

    logic          w_accept;
    logic          w_stall;
    logic          w_tc;
    logic          w_timeout;
    logic          w_tmr_clr;
    logic          w_tmr_ld;
    logic          w_tmr_en;
    logic [DW-1:0] w_rd_mux;

    assign w_accept  = (r_state == c_st_idle) && host.req;
    assign w_stall   = write_stalls(r_wr, r_addr, txff_full, tx_busy);
    assign w_timeout = (r_state == c_st_wait) && w_stall && w_tc;

    // Counter starts from zero on WAIT entry and only advances while stalling
    assign w_tmr_clr = (r_state == c_st_idle);
    assign w_tmr_ld  = (r_state == c_st_setup) && (w_next == c_st_wait);
    assign w_tmr_en  = (r_state == c_st_wait) && (w_next == c_st_wait);

    uart_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_tmr_clr),
        .i_ld     (w_tmr_ld),
        .i_ld_val ('0),
        .i_en     (w_tmr_en),
        .o_tc     (w_tc)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a clearing stall wins over the terminal count
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (host.req) begin
                    w_next = c_st_setup;
                end
            end
            c_st_setup: begin
                if (!r_wr) begin
                    w_next = c_st_ack;
                end else if (w_stall) begin
                    w_next = c_st_wait;
                end else begin
                    w_next = c_st_strobe;
                end
            end
            c_st_wait: begin
                if (!w_stall) begin
                    w_next = c_st_strobe;
                end else if (w_tc) begin
                    w_next = c_st_ack;
                end
            end
            c_st_strobe:  w_next = c_st_ack;
            c_st_ack:     w_next = c_st_release;
            c_st_release: begin
                if (!host.req) begin
                    w_next = c_st_idle;
                end
            end
            default:      w_next = c_st_idle;
        endcase
    end

    // Capture the request once; host changes are ignored until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_wr    <= host.wr;
            r_addr  <= host.addr;
            r_wdata <= host.wdata;
        end
    end

    // Read-data source selected by the captured address
    always_comb begin
        w_rd_mux = '0;
        case (r_addr)
            ADDR_BAUD:  w_rd_mux    = r_baud_div;
            ADDR_MODTX: w_rd_mux    = r_mode_cfg;
            ADDR_TXFF:  w_rd_mux[0] = txff_full;
            default:    w_rd_mux[0] = tx_busy;
        endcase
    end

    // Registered decoder, strobe and completion outputs, derived from the
    // state being entered so they line up with that state's cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec_ena   <= 1'b1;
            r_dec_sel   <= '0;
            r_reg_we    <= 1'b0;
            r_reg_wdata <= '0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_dec_ena <= !((w_next == c_st_setup) ||
                           (w_next == c_st_wait)  ||
                           (w_next == c_st_strobe));
            r_reg_we  <= (w_next == c_st_strobe);
            r_ack     <= (w_next == c_st_ack);
            r_err     <= (w_next == c_st_ack) && w_timeout;
            if (w_accept) begin
                r_dec_sel <= host.addr;
            end
            if (w_next == c_st_strobe) begin
                r_reg_wdata <= r_wdata;
            end
            if (w_next == c_st_ack) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    // Shadow registers follow the write strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_div <= BAUD_RST;
            r_mode_cfg <= MODE_RST;
        end else if (r_state == c_st_strobe) begin
            if (r_addr == ADDR_BAUD) begin
                r_baud_div <= r_wdata;
            end
            if (r_addr == ADDR_MODTX) begin
                r_mode_cfg <= r_wdata;
            end
        end
    end

    assign dec_ena    = r_dec_ena;
    assign dec_sel    = r_dec_sel;
    assign reg_we     = r_reg_we;
    assign reg_wdata  = r_reg_wdata;
    assign baud_div   = r_baud_div;
    assign mode_cfg   = r_mode_cfg;
    assign host.ack   = r_ack;
    assign host.err   = r_err;
    assign host.rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_uart_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_host_ctrl
// Description : Scoreboard bench for uart_host_ctrl. Stimulus pushes expected
//               completions and strobes; a monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_host_ctrl;

    localparam int DW       = 8;
    localparam int WAIT_MAX = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          txff_full = 1'b0;
    logic          tx_busy = 1'b0;
    logic          dec_ena;
    logic [1:0]    dec_sel;
    logic          reg_we;
    logic [DW-1:0] reg_wdata;
    logic [DW-1:0] baud_div;
    logic [DW-1:0] mode_cfg;

    uart_host_ctrl_if #(.DW(DW)) hif ();

    uart_host_ctrl #(
        .DW       (DW),
        .BAUD_RST (8'd27),
        .MODE_RST (8'd0),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .host      (hif),
        .dec_ena   (dec_ena),
        .dec_sel   (dec_sel),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .baud_div  (baud_div),
        .mode_cfg  (mode_cfg),
        .txff_full (txff_full),
        .tx_busy   (tx_busy)
    );

    typedef struct {
        logic [7:0] rdata;
        logic       chk_rd;
        logic       err;
        int         lat;
        int         t0;
    } ack_exp_t;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] data;
        int         lat;
        int         t0;
    } we_exp_t;

    ack_exp_t ack_q[$];
    we_exp_t  we_q[$];

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event not expected or missing (cycle %0d)", name, cyc);
    endtask

    // Monitor: every strobe and every completion must match a queued entry
    initial begin : monitor
        ack_exp_t ae;
        we_exp_t  we;
        int       dec_lows;
        dec_lows = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                dec_lows = 0;
            end else begin
                if (!dec_ena) dec_lows++;
                if (reg_we) begin
                    if (we_q.size() == 0) begin
                        flag("unexpected_reg_we");
                    end else begin
                        we = we_q.pop_front();
                        chk("we_sel", {30'd0, dec_sel}, {30'd0, we.sel});
                        chk("we_data", {24'd0, reg_wdata}, {24'd0, we.data});
                        chk("we_dec_ena", {31'd0, dec_ena}, 32'd0);
                        chk("we_latency", cyc - we.t0, we.lat);
                    end
                end
                if (hif.ack) begin
                    if (ack_q.size() == 0) begin
                        flag("unexpected_ack");
                    end else begin
                        ae = ack_q.pop_front();
                        chk("ack_err", {31'd0, hif.err}, {31'd0, ae.err});
                        if (ae.chk_rd) chk("ack_rdata", {24'd0, hif.rdata}, {24'd0, ae.rdata});
                        chk("ack_latency", cyc - ae.t0, ae.lat);
                        chk("ack_dec_ena", {31'd0, dec_ena}, 32'd1);
                        chk("dec_ena_low_cycles", dec_lows, ae.lat - 1);
                    end
                    dec_lows = 0;
                end
            end
        end
    end

    // Issue a request at the current negedge; ack_lat < 0 means no completion
    // is expected, we_lat < 0 means no strobe is expected
    task automatic start(input logic w, input logic [1:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd, input logic exp_err,
                         input int ack_lat, input int we_lat);
        ack_exp_t ae;
        we_exp_t  we;
        hif.req   = 1'b1;
        hif.wr    = w;
        hif.addr  = a;
        hif.wdata = d;
        if (ack_lat >= 0) begin
            ae.rdata = exp_rd; ae.chk_rd = !w; ae.err = exp_err;
            ae.lat = ack_lat; ae.t0 = cyc;
            ack_q.push_back(ae);
        end
        if (we_lat >= 0) begin
            we.sel = a; we.data = d; we.lat = we_lat; we.t0 = cyc;
            we_q.push_back(we);
        end
    endtask

    // Advance to the negedge at which ack is high, bounded
    task automatic wait_ack();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!hif.ack && n < 200);
        if (!hif.ack) flag("ack_timeout");
    endtask

    // Keep req high for 'hold' more cycles, drop it, then let the DUT idle
    task automatic release_req(input int hold);
        repeat (hold) @(negedge clk);
        hif.req   = 1'b0;
        hif.wr    = 1'b0;
        hif.addr  = 2'd0;
        hif.wdata = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        hif.req = 1'b0; hif.wr = 1'b0; hif.addr = 2'd0; hif.wdata = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'd0, hif.ack}, 32'd0);
        chk("rst_err", {31'd0, hif.err}, 32'd0);
        chk("rst_rdata", {24'd0, hif.rdata}, 32'd0);
        chk("rst_dec_ena", {31'd0, dec_ena}, 32'd1);
        chk("rst_dec_sel", {30'd0, dec_sel}, 32'd0);
        chk("rst_reg_we", {31'd0, reg_we}, 32'd0);
        chk("rst_reg_wdata", {24'd0, reg_wdata}, 32'd0);
        chk("rst_baud", {24'd0, baud_div}, 32'd27);
        chk("rst_mode", {24'd0, mode_cfg}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Read baud after reset
        start(1'b0, 2'd0, 8'h00, 8'd27, 1'b0, 2, -1);
        wait_ack();
        chk("read0_dec_sel", {30'd0, dec_sel}, 32'd0);
        release_req(0);

        // Unstalled writes to mode and baud
        start(1'b1, 2'd1, 8'hA5, 8'h00, 1'b0, 3, 2);
        wait_ack();
        chk("mode_after_write", {24'd0, mode_cfg}, 32'hA5);
        release_req(0);
        start(1'b1, 2'd0, 8'h10, 8'h00, 1'b0, 3, 2);
        wait_ack();
        chk("baud_after_write", {24'd0, baud_div}, 32'h10);
        release_req(0);

        // Read back shadows
        start(1'b0, 2'd1, 8'h00, 8'hA5, 1'b0, 2, -1);
        wait_ack(); release_req(0);
        start(1'b0, 2'd0, 8'h00, 8'h10, 1'b0, 2, -1);
        wait_ack(); release_req(0);

        // TX FIFO full for five wait cycles, then drains
        txff_full = 1'b1;
        start(1'b1, 2'd2, 8'h41, 8'h00, 1'b0, 8, 7);
        repeat (6) @(negedge clk);
        txff_full = 1'b0;
        wait_ack(); release_req(0);

        // Transmitter busy throughout: timeout with error and no strobe
        tx_busy = 1'b1;
        start(1'b1, 2'd3, 8'h55, 8'h00, 1'b1, 2 + WAIT_MAX, -1);
        wait_ack();
        chk("timeout_baud", {24'd0, baud_div}, 32'h10);
        chk("timeout_mode", {24'd0, mode_cfg}, 32'hA5);
        release_req(0);

        // Status reads never stall
        start(1'b0, 2'd3, 8'h00, 8'h01, 1'b0, 2, -1);
        wait_ack(); release_req(0);
        tx_busy = 1'b0;
        txff_full = 1'b1;
        start(1'b0, 2'd2, 8'h00, 8'h01, 1'b0, 2, -1);
        wait_ack(); release_req(0);
        txff_full = 1'b0;
        start(1'b0, 2'd3, 8'h00, 8'h00, 1'b0, 2, -1);
        wait_ack(); release_req(0);

        // Stall clears in the same cycle the counter reaches its terminal value
        tx_busy = 1'b1;
        start(1'b1, 2'd3, 8'h66, 8'h00, 1'b0, 3 + WAIT_MAX, 2 + WAIT_MAX);
        repeat (1 + WAIT_MAX) @(negedge clk);
        tx_busy = 1'b0;
        wait_ack(); release_req(0);

        // req held long after ack: only one completion
        start(1'b0, 2'd1, 8'h00, 8'hA5, 1'b0, 2, -1);
        wait_ack(); release_req(10);
        start(1'b0, 2'd0, 8'h00, 8'h10, 1'b0, 2, -1);
        wait_ack(); release_req(0);

        // Reset during a stall aborts the write
        tx_busy = 1'b1;
        start(1'b1, 2'd3, 8'h77, 8'h00, 1'b0, -1, -1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ack", {31'd0, hif.ack}, 32'd0);
        chk("abort_reg_we", {31'd0, reg_we}, 32'd0);
        chk("abort_dec_ena", {31'd0, dec_ena}, 32'd1);
        chk("abort_baud", {24'd0, baud_div}, 32'd27);
        chk("abort_mode", {24'd0, mode_cfg}, 32'd0);
        hif.req = 1'b0;
        tx_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_abort_dec_ena", {31'd0, dec_ena}, 32'd1);
        start(1'b0, 2'd0, 8'h00, 8'd27, 1'b0, 2, -1);
        wait_ack(); release_req(0);
        start(1'b0, 2'd1, 8'h00, 8'h00, 1'b0, 2, -1);
        wait_ack(); release_req(0);

        repeat (3) @(negedge clk);
        chk("ack_queue_drained", ack_q.size(), 32'd0);
        chk("we_queue_drained", we_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
